// File: rtl/square_64b_seq.sv
// Sequential unsigned squarer: returns x*x by iterative shift-add, BITS_PER_CYCLE
// multiplier bits per cycle, with valid/ready handshakes on both sides.
module square_64b_seq #(
  parameter int IN_W           = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in0,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*IN_W-1:0]   out0,
  output logic                busy
);

  localparam int OUT_W = 2 * IN_W;
  localparam int N     = IN_W / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   a_q, a_d;
  logic [IN_W-1:0]    b_q, b_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [OUT_W-1:0]   out0_q, out0_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   acc_sum;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    count_d     = count_q;
    out0_d      = out0_q;
    out_valid_d = out_valid_q;

    // Partial products for the multiplier bits consumed this cycle
    acc_sum = acc_q;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_q[j]) acc_sum = acc_sum + (a_q << j);
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = {{IN_W{1'b0}}, in0};
          b_d     = in0;
          acc_d   = '0;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_sum;
        a_d     = a_q << BITS_PER_CYCLE;
        b_d     = b_q >> BITS_PER_CYCLE;
        count_d = count_q + 1'b1;
        // Fixed latency: no early exit even once the multiplier runs out of ones
        if (count_q == CNT_W'(N - 1)) begin
          out0_d      = acc_sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      count_q     <= '0;
      out0_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      count_q     <= count_d;
      out0_q      <= out0_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out0      = out0_q;

endmodule

// File: tb/tb_square_64b_seq.sv
// Self-checking bench for square_64b_seq: directed corner operands, back-pressure,
// mid-calculation reset and random operands against a plain 128-bit multiply model.
module tb_square_64b_seq;

  localparam int N = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in0;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out0;
  logic          busy;

  int n_compared = 0;
  int n_mismatched = 0;

  square_64b_seq #(.IN_W(64), .BITS_PER_CYCLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] square_model(input logic [63:0] x);
    logic [127:0] wide;
    wide = {64'd0, x};
    return wide * wide;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present x for one accepting edge, then scramble in0 to show it is sampled only at accept
  task automatic apply_stimulus(input logic [63:0] x);
    check_output("accept_ready", {127'd0, in_ready}, 128'd1);
    in0      = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in0      = {$urandom(), $urandom()};
    check_output("busy_after_accept", {127'd0, busy}, 128'd1);
  endtask

  // Wait (bounded) for the result, check latency and value, optionally stall, then hand it off
  task automatic collect_result(input string tag, input logic [63:0] x, input int stall);
    int cycles;
    logic [127:0] expected;
    expected = square_model(x);
    cycles = 0;
    while (!out_valid && cycles < 4 * N) begin
      tick();
      cycles++;
    end
    check_output({tag, "_latency"}, 128'(cycles), 128'(N));
    check_output({tag, "_value"}, out0, expected);
    for (int i = 0; i < stall; i++) begin
      tick();
      if (out_valid !== 1'b1 || out0 !== expected || in_ready !== 1'b0)
        check_output({tag, "_stall"}, {out_valid, in_ready, out0[125:0]}, {2'b10, expected[125:0]});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output({tag, "_handoff_valid"}, {127'd0, out_valid}, 128'd0);
    check_output({tag, "_held_value"}, out0, expected);
  endtask

  initial begin
    logic [63:0] x;
    int waited;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in0       = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_output("reset_in_ready", {127'd0, in_ready}, 128'd1);
    check_output("reset_busy", {127'd0, busy}, 128'd0);
    check_output("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check_output("reset_out0", out0, 128'd0);

    apply_stimulus(64'd0);
    collect_result("zero", 64'd0, 0);
    apply_stimulus(64'd1);
    collect_result("one", 64'd1, 0);
    apply_stimulus(64'hFFFF_FFFF);
    collect_result("max32", 64'hFFFF_FFFF, 0);
    apply_stimulus(64'h1_0000_0000);
    collect_result("pow32", 64'h1_0000_0000, 0);
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF);
    collect_result("max64", 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check_output("max64_literal", out0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    // Back-pressure: result held 20 cycles while a new operand waits
    apply_stimulus(64'd12345);
    waited = 0;
    while (!out_valid && waited < 4 * N) begin
      tick();
      waited++;
    end
    in0      = 64'd99;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out0 !== square_model(64'd12345))
        check_output("stall_hold", {out_valid, in_ready, out0[125:0]}, {2'b10, square_model(64'd12345)});
    end
    check_output("stall_value", out0, square_model(64'd12345));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("stall_release_idle", {127'd0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
    check_output("stall_next_accept", {127'd0, busy}, 128'd1);
    collect_result("after_stall", 64'd99, 0);

    // Reset in the middle of a calculation discards it completely
    apply_stimulus(64'd5);
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("midreset_in_ready", {127'd0, in_ready}, 128'd1);
    check_output("midreset_out_valid", {127'd0, out_valid}, 128'd0);
    check_output("midreset_out0", out0, 128'd0);
    apply_stimulus(64'd7);
    collect_result("after_reset", 64'd7, 0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: x = {$urandom(), $urandom()};
        1: x = 64'($urandom_range(0, 1000));
        2: x = {32'hFFFF_FFFF, $urandom()};
        default: x = 64'd1 << $urandom_range(0, 63);
      endcase
      apply_stimulus(x);
      collect_result("random", x, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
